// File: rtl/serial_out_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : serial_out_pkg
// Brief   : Shared state encoding, address and status-bit constants for the
//           serial output port. Optional parity: SERIAL_OUT_PARITY_EN.
// Rev     : 1.0
//------------------------------------------------------------------------------
package serial_out_pkg;

  localparam logic [31:0] c_SERIAL_OUT_ADDR = 32'hFFFF_FFFB;

  localparam int c_STAT_BUSY    = 0;
  localparam int c_STAT_FULL    = 1;
  localparam int c_STAT_EMPTY   = 2;
  localparam int c_STAT_OVF     = 3;
  localparam int c_STAT_CNT_LSB = 4;

  localparam int c_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_OUT_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

`ifdef SERIAL_OUT_PARITY_EN
  function automatic logic even_parity(input logic [c_DATA_BITS-1:0] b);
    return ^b;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/serial_out_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : serial_out_fifo
// Brief   : Synchronous power-of-two FIFO with registered storage, occupancy
//           count and full/empty flags. Push on full is taken only with a pop.
// Rev     : 1.0
//------------------------------------------------------------------------------
module serial_out_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  // When full, the pop frees the very slot the push writes into.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_out_port.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : serial_out_port
// Brief   : Memory-mapped UART transmitter with TX FIFO, sticky overflow and
//           status word. Define SERIAL_OUT_PARITY_EN for an even-parity bit.
// Rev     : 1.0
//------------------------------------------------------------------------------
module serial_out_port
  import serial_out_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t                r_state;
  tx_state_t                w_state_next;
  logic [BAUD_W-1:0]        r_baud;
  logic [2:0]               r_bit;
  logic [c_DATA_BITS-1:0]   r_shift;
  logic                     r_txd;
  logic                     r_ovf;
  logic                     w_txd_next;
  logic                     w_baud_done;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_wr_byte;
  logic                     w_wr_clr;
  logic [c_DATA_BITS-1:0]   w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [CW-1:0]            w_count;
  logic                     w_unused;
`ifdef SERIAL_OUT_PARITY_EN
  logic                     r_parity;
`endif

  assign w_unused  = ^wdata[31:9];
  assign w_wr_byte = we & ~wdata[8];
  assign w_wr_clr  = we & wdata[8];
  assign w_push    = w_wr_byte & (~w_full | w_pop);

  serial_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (wdata[7:0]),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_baud_done = (r_baud == c_BAUD_LAST);

  // w_txd_next is the line level for the current state; registering it puts
  // the start bit one edge after the pop.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_txd_next   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_txd_next = 1'b0;
        if (w_baud_done) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        w_txd_next = r_shift[0];
        if (w_baud_done && (r_bit == 3'd7)) begin
`ifdef SERIAL_OUT_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_OUT_PARITY_EN
      ST_PARITY: begin
        w_txd_next = r_parity;
        if (w_baud_done) w_state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_baud_done) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_txd   <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_txd   <= w_txd_next;
      if (w_pop) begin
        r_shift <= w_head;
        r_baud  <= '0;
        r_bit   <= '0;
      end else if (r_state != ST_IDLE) begin
        if (w_baud_done) begin
          r_baud <= '0;
          if (r_state == ST_DATA) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
          end
        end else begin
          r_baud <= r_baud + BAUD_W'(1);
        end
      end
    end
  end

`ifdef SERIAL_OUT_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_parity <= 1'b0;
    else if (w_pop) r_parity <= even_parity(w_head);
  end
`endif

  // Overflow only when a byte is truly dropped: full and no pop this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_ovf <= 1'b0;
    else if (w_wr_clr)                      r_ovf <= 1'b0;
    else if (w_wr_byte && w_full && !w_pop) r_ovf <= 1'b1;
  end

  always_comb begin
    rdata                         = '0;
    rdata[c_STAT_BUSY]            = (r_state != ST_IDLE);
    rdata[c_STAT_FULL]            = w_full;
    rdata[c_STAT_EMPTY]           = w_empty;
    rdata[c_STAT_OVF]             = r_ovf;
    rdata[c_STAT_CNT_LSB +: CW]   = w_count;
  end

  assign txd = r_txd;
  assign irq = w_empty & (r_state == ST_IDLE);

endmodule
`default_nettype wire
